// File: rtl/operand_encoder_pkg.sv
// rtl/operand_encoder_pkg.sv - shared types and ModRM field constants for the operand encoder
package operand_encoder_pkg;

    typedef enum logic [3:0] {
        MODE_NONE   = 4'd0,
        MODE_REG    = 4'd1,
        MODE_REG_IV = 4'd2,
        MODE_EV     = 4'd3,
        MODE_EV_GV  = 4'd4,
        MODE_GV_EV  = 4'd5,
        MODE_EV_IB  = 4'd6,
        MODE_EV_IZ  = 4'd7,
        MODE_JZ     = 4'd8,
        MODE_JB     = 4'd9
    } opd_mode_t;

    typedef enum logic [1:0] {
        TYPE_REGISTER  = 2'd0,
        TYPE_BASE      = 2'd1,
        TYPE_BASE_DISP = 2'd2,
        TYPE_RIP_DISP  = 2'd3
    } opd_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MODRM = 2'd1,
        ST_DISP  = 2'd2,
        ST_IMM   = 2'd3
    } enc_state_t;

    // {rex bit, low 3 bits} register identifier
    typedef logic [3:0] reg_id_t;

    localparam logic [1:0] MOD_IND    = 2'b00;
    localparam logic [1:0] MOD_DISP8  = 2'b01;
    localparam logic [1:0] MOD_DISP32 = 2'b10;
    localparam logic [1:0] MOD_REG    = 2'b11;

    localparam logic [2:0] RM_RIP = 3'b101;
    localparam logic [2:0] RM_SIB = 3'b100;
    localparam logic [2:0] RM_BP  = 3'b101;

endpackage

// File: rtl/operand_encoder_modrm_builder.sv
// rtl/operand_encoder_modrm_builder.sv - combinational ModRM byte, displacement length and REX bits
module modrm_builder
    import operand_encoder_pkg::*;
(
    input  opd_mode_t   i_mode,
    input  opd_type_t   i_ev_type,
    input  reg_id_t     i_ev_reg,
    input  reg_id_t     i_g_reg,
    input  logic [2:0]  i_ext,
    input  logic [31:0] i_disp,
    output logic        o_has_modrm,
    output logic [7:0]  o_modrm,
    output logic [2:0]  o_disp_len,
    output logic        o_rex_r,
    output logic        o_rex_b,
    output logic        o_err
);

    logic       w_gv;
    logic       w_fits8;
    logic [1:0] w_mod;
    logic [2:0] w_rm;
    logic [2:0] w_reg;

    always_comb begin
        w_gv        = (i_mode == MODE_EV_GV) || (i_mode == MODE_GV_EV);
        o_has_modrm = w_gv || (i_mode == MODE_EV) || (i_mode == MODE_EV_IB) || (i_mode == MODE_EV_IZ);
        w_fits8     = ($signed(i_disp) >= -32'sd128) && ($signed(i_disp) <= 32'sd127);
        w_reg       = w_gv ? i_g_reg[2:0] : i_ext;
        w_rm        = i_ev_reg[2:0];
        w_mod       = MOD_REG;
        o_disp_len  = 3'd0;
        o_rex_b     = i_ev_reg[3];
        o_err       = 1'b0;

        case (i_ev_type)
            TYPE_REGISTER: ;
            // rbp/r13 with mod=00 would mean RIP-relative, so it needs an explicit zero disp8
            TYPE_BASE: begin
                o_err = (w_rm == RM_SIB);
                if (w_rm == RM_BP) begin
                    w_mod      = MOD_DISP8;
                    o_disp_len = 3'd1;
                end else begin
                    w_mod = MOD_IND;
                end
            end
            TYPE_BASE_DISP: begin
                o_err = (w_rm == RM_SIB);
                if (w_fits8) begin
                    w_mod      = MOD_DISP8;
                    o_disp_len = 3'd1;
                end else begin
                    w_mod      = MOD_DISP32;
                    o_disp_len = 3'd4;
                end
            end
            default: begin
                w_mod      = MOD_IND;
                w_rm       = RM_RIP;
                o_disp_len = 3'd4;
                o_rex_b    = 1'b0;
            end
        endcase

        o_rex_r = w_gv & i_g_reg[3];
        o_modrm = {w_mod, w_reg, w_rm};

        if (!o_has_modrm) begin
            o_modrm    = 8'h00;
            o_disp_len = 3'd0;
            o_rex_r    = 1'b0;
            o_rex_b    = 1'b0;
            o_err      = 1'b0;
        end
    end

endmodule

// File: rtl/operand_encoder.sv
// rtl/operand_encoder.sv - serialises one operand descriptor into ModRM, displacement and immediate bytes
module operand_encoder
    import operand_encoder_pkg::*;
#(
    parameter int MAX_BYTES = 9,
    parameter int IMM_W     = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_mode,
    input  logic [1:0]       in_ev_type,
    input  logic [3:0]       in_ev_reg,
    input  logic [3:0]       in_g_reg,
    input  logic [2:0]       in_ext,
    input  logic [31:0]      in_disp,
    input  logic [IMM_W-1:0] in_imm,
    input  logic             in_rex_w,
    input  logic             in_osz16,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             info_valid,
    output logic             info_rex_r,
    output logic             info_rex_b,
    output logic [2:0]       info_opreg,
    output logic             err
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    opd_mode_t  w_mode;
    opd_type_t  w_ev_type;
    logic       w_has_modrm;
    logic [7:0] w_modrm;
    logic [2:0] w_mr_dlen;
    logic       w_mr_rex_r;
    logic       w_mr_rex_b;
    logic       w_err;

    logic [CNT_W-1:0] w_dlen;
    logic [CNT_W-1:0] w_ilen;
    logic [CNT_W-1:0] w_total;
    logic [31:0]      w_disp;
    logic             w_rex_b;
    logic [2:0]       w_opreg;

    enc_state_t       w_nx_state;
    logic [CNT_W-1:0] w_nx_cnt;
    logic [7:0]       w_nx_byte;
    logic             w_shift_disp;
    logic             w_shift_imm;

    enc_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_left;
    logic [CNT_W-1:0] r_dlen;
    logic [CNT_W-1:0] r_ilen;
    logic [31:0]      r_disp;
    logic [IMM_W-1:0] r_imm;
    logic             r_out_valid;
    logic [7:0]       r_out_byte;
    logic             r_out_last;
    logic             r_info_valid;
    logic             r_info_rex_r;
    logic             r_info_rex_b;
    logic [2:0]       r_info_opreg;
    logic             r_err;

    assign w_mode    = opd_mode_t'(in_mode);
    assign w_ev_type = opd_type_t'(in_ev_type);

    modrm_builder u_modrm_builder (
        .i_mode      (w_mode),
        .i_ev_type   (w_ev_type),
        .i_ev_reg    (in_ev_reg),
        .i_g_reg     (in_g_reg),
        .i_ext       (in_ext),
        .i_disp      (in_disp),
        .o_has_modrm (w_has_modrm),
        .o_modrm     (w_modrm),
        .o_disp_len  (w_mr_dlen),
        .o_rex_r     (w_mr_rex_r),
        .o_rex_b     (w_mr_rex_b),
        .o_err       (w_err)
    );

    always_comb begin
        w_dlen  = CNT_W'(w_mr_dlen);
        w_ilen  = '0;
        w_rex_b = w_mr_rex_b;
        w_opreg = 3'd0;
        w_disp  = (w_has_modrm && (w_ev_type == TYPE_BASE)) ? 32'h0 : in_disp;
        case (w_mode)
            MODE_REG: begin
                w_rex_b = in_g_reg[3];
                w_opreg = in_g_reg[2:0];
            end
            MODE_REG_IV: begin
                w_rex_b = in_g_reg[3];
                w_opreg = in_g_reg[2:0];
                w_ilen  = in_rex_w ? CNT_W'(8) : (in_osz16 ? CNT_W'(2) : CNT_W'(4));
            end
            MODE_EV_IB: w_ilen = CNT_W'(1);
            MODE_EV_IZ: w_ilen = CNT_W'(4);
            MODE_JZ:    w_dlen = CNT_W'(4);
            MODE_JB:    w_dlen = CNT_W'(1);
            default: ;
        endcase
        w_total = {{(CNT_W-1){1'b0}}, w_has_modrm} + w_dlen + w_ilen;
    end

    // Next byte after the one currently presented; disp/imm registers always hold unsent bytes at [7:0]
    always_comb begin
        w_nx_state   = ST_IDLE;
        w_nx_cnt     = '0;
        w_nx_byte    = 8'h00;
        w_shift_disp = 1'b0;
        w_shift_imm  = 1'b0;
        case (r_state)
            ST_MODRM, ST_DISP: begin
                if ((r_state == ST_DISP && r_cnt > CNT_W'(1)) ||
                    (r_state == ST_MODRM && r_dlen != '0)) begin
                    w_nx_state   = ST_DISP;
                    w_nx_cnt     = (r_state == ST_MODRM) ? r_dlen : r_cnt - CNT_W'(1);
                    w_nx_byte    = r_disp[7:0];
                    w_shift_disp = 1'b1;
                end else if (r_ilen != '0) begin
                    w_nx_state  = ST_IMM;
                    w_nx_cnt    = r_ilen;
                    w_nx_byte   = r_imm[7:0];
                    w_shift_imm = 1'b1;
                end
            end
            ST_IMM: begin
                if (r_cnt > CNT_W'(1)) begin
                    w_nx_state  = ST_IMM;
                    w_nx_cnt    = r_cnt - CNT_W'(1);
                    w_nx_byte   = r_imm[7:0];
                    w_shift_imm = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_left       <= '0;
            r_dlen       <= '0;
            r_ilen       <= '0;
            r_disp       <= '0;
            r_imm        <= '0;
            r_out_valid  <= 1'b0;
            r_out_byte   <= 8'h00;
            r_out_last   <= 1'b0;
            r_info_valid <= 1'b0;
            r_info_rex_r <= 1'b0;
            r_info_rex_b <= 1'b0;
            r_info_opreg <= 3'd0;
            r_err        <= 1'b0;
        end else begin
            r_info_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_err) begin
                            r_err <= 1'b1;
                        end else begin
                            r_info_valid <= 1'b1;
                            r_info_rex_r <= w_mr_rex_r;
                            r_info_rex_b <= w_rex_b;
                            r_info_opreg <= w_opreg;
                            r_dlen       <= w_dlen;
                            r_ilen       <= w_ilen;
                            r_left       <= w_total;
                            r_out_last   <= (w_total == CNT_W'(1));
                            r_disp       <= w_disp;
                            r_imm        <= in_imm;
                            if (w_has_modrm) begin
                                r_state     <= ST_MODRM;
                                r_out_valid <= 1'b1;
                                r_out_byte  <= w_modrm;
                            end else if (w_dlen != '0) begin
                                r_state     <= ST_DISP;
                                r_cnt       <= w_dlen;
                                r_out_valid <= 1'b1;
                                r_out_byte  <= w_disp[7:0];
                                r_disp      <= w_disp >> 8;
                            end else if (w_ilen != '0) begin
                                r_state     <= ST_IMM;
                                r_cnt       <= w_ilen;
                                r_out_valid <= 1'b1;
                                r_out_byte  <= in_imm[7:0];
                                r_imm       <= in_imm >> 8;
                            end
                        end
                    end
                end
                default: begin
                    if (r_out_valid && out_ready) begin
                        r_state     <= w_nx_state;
                        r_cnt       <= w_nx_cnt;
                        r_out_byte  <= w_nx_byte;
                        r_out_valid <= (w_nx_state != ST_IDLE);
                        r_out_last  <= (r_left == CNT_W'(2));
                        r_left      <= r_left - CNT_W'(1);
                        if (w_shift_disp) r_disp <= r_disp >> 8;
                        if (w_shift_imm)  r_imm  <= r_imm >> 8;
                    end
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign out_byte   = r_out_byte;
    assign out_last   = r_out_last;
    assign info_valid = r_info_valid;
    assign info_rex_r = r_info_rex_r;
    assign info_rex_b = r_info_rex_b;
    assign info_opreg = r_info_opreg;
    assign err        = r_err;

endmodule

// File: tb/tb_operand_encoder.sv
// tb/tb_operand_encoder.sv - scoreboard bench for operand_encoder with a byte-list reference model
module tb_operand_encoder;
    import operand_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    opd_mode_t   in_mode = MODE_NONE;
    opd_type_t   in_ev_type = TYPE_REGISTER;
    logic [3:0]  in_ev_reg = '0;
    logic [3:0]  in_g_reg = '0;
    logic [2:0]  in_ext = '0;
    logic [31:0] in_disp = '0;
    logic [63:0] in_imm = '0;
    logic        in_rex_w = 1'b0;
    logic        in_osz16 = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        info_valid;
    logic        info_rex_r;
    logic        info_rex_b;
    logic [2:0]  info_opreg;
    logic        err;

    operand_encoder #(.MAX_BYTES(9), .IMM_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_ev_type(in_ev_type), .in_ev_reg(in_ev_reg),
        .in_g_reg(in_g_reg), .in_ext(in_ext), .in_disp(in_disp), .in_imm(in_imm),
        .in_rex_w(in_rex_w), .in_osz16(in_osz16),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
        .info_valid(info_valid), .info_rex_r(info_rex_r), .info_rex_b(info_rex_b),
        .info_opreg(info_opreg), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        opd_mode_t   mode;
        opd_type_t   ev_type;
        logic [3:0]  ev_reg;
        logic [3:0]  g_reg;
        logic [2:0]  ext;
        logic [31:0] disp;
        logic [63:0] imm;
        logic        rex_w;
        logic        osz16;
    } desc_t;

    typedef struct {
        bit       is_err;
        bit       rr;
        bit       rb;
        bit [2:0] opreg;
    } evt_t;

    logic [8:0] exp_bytes[$];
    evt_t       exp_evts[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    bit         bp_random = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic desc_t mk(opd_mode_t m, opd_type_t t, logic [3:0] ev, logic [3:0] g,
                                 logic [2:0] ext, logic [31:0] disp, logic [63:0] imm,
                                 logic rw, logic o16);
        desc_t d;
        d.mode = m; d.ev_type = t; d.ev_reg = ev; d.g_reg = g; d.ext = ext;
        d.disp = disp; d.imm = imm; d.rex_w = rw; d.osz16 = o16;
        return d;
    endfunction

    // Expected operand bytes as an x86 assembler would lay them out
    task automatic model(input desc_t d);
        logic [7:0]  ops[$];
        evt_t        e;
        logic [1:0]  md;
        logic [2:0]  rg, rm;
        logic [31:0] dv;
        int          dlen, ilen, sd;
        bit          gv;
        e = '{default: 0};
        dlen = 0; ilen = 0; dv = d.disp; md = 2'b00;
        sd = int'($signed(d.disp));
        gv = (d.mode == MODE_EV_GV) || (d.mode == MODE_GV_EV);
        if (gv || d.mode == MODE_EV || d.mode == MODE_EV_IB || d.mode == MODE_EV_IZ) begin
            rg = gv ? d.g_reg[2:0] : d.ext;
            rm = d.ev_reg[2:0];
            e.rr = gv && d.g_reg[3];
            e.rb = d.ev_reg[3];
            if ((d.ev_type == TYPE_BASE || d.ev_type == TYPE_BASE_DISP) && rm == 3'd4)
                e.is_err = 1;
            case (d.ev_type)
                TYPE_REGISTER: md = 2'b11;
                TYPE_BASE: if (rm == 3'd5) begin md = 2'b01; dlen = 1; dv = 0; end
                TYPE_BASE_DISP:
                    if (sd >= -128 && sd <= 127) begin md = 2'b01; dlen = 1; end
                    else begin md = 2'b10; dlen = 4; end
                default: begin md = 2'b00; rm = 3'd5; dlen = 4; e.rb = 0; end
            endcase
            ops.push_back({md, rg, rm});
        end else if (d.mode == MODE_REG || d.mode == MODE_REG_IV) begin
            e.rb = d.g_reg[3];
            e.opreg = d.g_reg[2:0];
        end
        if (d.mode == MODE_JZ) dlen = 4;
        if (d.mode == MODE_JB) dlen = 1;
        if (d.mode == MODE_EV_IB) ilen = 1;
        if (d.mode == MODE_EV_IZ) ilen = 4;
        if (d.mode == MODE_REG_IV) ilen = d.rex_w ? 8 : (d.osz16 ? 2 : 4);
        if (e.is_err) begin
            exp_evts.push_back(e);
            return;
        end
        for (int i = 0; i < dlen; i++) ops.push_back(8'((dv >> (8 * i)) & 32'hFF));
        for (int i = 0; i < ilen; i++) ops.push_back(8'((d.imm >> (8 * i)) & 64'hFF));
        for (int i = 0; i < ops.size(); i++) exp_bytes.push_back({i == ops.size() - 1, ops[i]});
        exp_evts.push_back(e);
    endtask

    task automatic send(input desc_t d);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_mode = d.mode; in_ev_type = d.ev_type; in_ev_reg = d.ev_reg; in_g_reg = d.g_reg;
        in_ext = d.ext; in_disp = d.disp; in_imm = d.imm; in_rex_w = d.rex_w; in_osz16 = d.osz16;
        in_valid = 1'b1;
        model(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin : monitor
        evt_t       e;
        logic [8:0] b;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (info_valid || err) begin
                    if (exp_evts.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_info: got info=%0b err=%0b want none", info_valid, err);
                    end else begin
                        e = exp_evts.pop_front();
                        chk("err", 64'(err), 64'(e.is_err));
                        chk("info_valid", 64'(info_valid), 64'(!e.is_err));
                        if (!e.is_err) begin
                            chk("rex_r", 64'(info_rex_r), 64'(e.rr));
                            chk("rex_b", 64'(info_rex_b), 64'(e.rb));
                            chk("opreg", 64'(info_opreg), 64'(e.opreg));
                        end
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_bytes.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_byte: got %0h want none", out_byte);
                    end else begin
                        b = exp_bytes.pop_front();
                        chk("byte", 64'({out_last, out_byte}), 64'(b));
                    end
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : main
        desc_t d;
        int    w;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_info_valid", 64'(info_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_out_byte", 64'({out_last, out_byte}), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        send(mk(MODE_EV_GV, TYPE_REGISTER, 4'd3, 4'd9, 3'd0, 32'd0, 64'd0, 1'b0, 1'b0));
        chk("tp_ev_gv_byte", 64'({out_last, out_byte}), 64'h1CB);
        chk("tp_ev_gv_rex_r", 64'(info_rex_r), 64'd1);
        send(mk(MODE_EV_IZ, TYPE_BASE_DISP, 4'd5, 4'd0, 3'd0, -32'sd8, 64'h12345678, 1'b0, 1'b0));
        send(mk(MODE_GV_EV, TYPE_BASE, 4'd13, 4'd0, 3'd0, 32'h55, 64'd0, 1'b0, 1'b0));
        send(mk(MODE_GV_EV, TYPE_RIP_DISP, 4'd0, 4'd0, 3'd0, 32'h100, 64'd0, 1'b0, 1'b0));
        send(mk(MODE_REG_IV, TYPE_REGISTER, 4'd0, 4'd8, 3'd0, 32'd0, 64'h1122334455667788, 1'b1, 1'b0));
        send(mk(MODE_REG_IV, TYPE_REGISTER, 4'd0, 4'd8, 3'd0, 32'd0, 64'h1122334455667788, 1'b0, 1'b1));
        send(mk(MODE_REG_IV, TYPE_REGISTER, 4'd0, 4'd2, 3'd0, 32'd0, 64'h1122334455667788, 1'b1, 1'b1));
        send(mk(MODE_EV_IB, TYPE_BASE_DISP, 4'd1, 4'd0, 3'd7, 32'd127, 64'hAB, 1'b0, 1'b0));
        send(mk(MODE_EV_IB, TYPE_BASE_DISP, 4'd1, 4'd0, 3'd7, -32'sd128, 64'hCD, 1'b0, 1'b0));
        send(mk(MODE_EV, TYPE_BASE_DISP, 4'd10, 4'd0, 3'd2, 32'd128, 64'd0, 1'b0, 1'b0));
        send(mk(MODE_EV, TYPE_BASE_DISP, 4'd10, 4'd0, 3'd2, -32'sd129, 64'd0, 1'b0, 1'b0));
        send(mk(MODE_JB, TYPE_REGISTER, 4'd0, 4'd0, 3'd0, 32'h1234, 64'd0, 1'b0, 1'b0));
        send(mk(MODE_JZ, TYPE_REGISTER, 4'd0, 4'd0, 3'd0, 32'hDEADBEEF, 64'd0, 1'b0, 1'b0));
        send(mk(MODE_NONE, TYPE_REGISTER, 4'd0, 4'd0, 3'd0, 32'd0, 64'd0, 1'b0, 1'b0));
        send(mk(MODE_REG, TYPE_REGISTER, 4'd0, 4'd15, 3'd0, 32'd0, 64'd0, 1'b0, 1'b0));

        send(mk(MODE_EV, TYPE_BASE, 4'd4, 4'd0, 3'd0, 32'd0, 64'd0, 1'b0, 1'b0));
        chk("sib_err_pulse", 64'(err), 64'd1);
        chk("sib_no_byte", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("sib_ready", 64'(in_ready), 64'd1);
        chk("sib_err_clear", 64'(err), 64'd0);

        send(mk(MODE_EV_IZ, TYPE_BASE_DISP, 4'd1, 4'd0, 3'd0, 32'h11223344, 64'd0, 1'b0, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_byte", 64'({out_valid, out_last, out_byte}), 64'h233);
        end
        out_ready = 1'b1;

        send(mk(MODE_REG_IV, TYPE_REGISTER, 4'd0, 4'd0, 3'd0, 32'd0, 64'h0102030405060708, 1'b1, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        exp_bytes.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", 64'(in_ready), 64'd1);
        chk("rst_release_valid", 64'(out_valid), 64'd0);

        bp_random = 1'b1;
        for (int n = 0; n < 300; n++) begin
            d.mode    = opd_mode_t'($urandom_range(0, 9));
            d.ev_type = opd_type_t'($urandom_range(0, 3));
            d.ev_reg  = 4'($urandom_range(0, 15));
            d.g_reg   = 4'($urandom_range(0, 15));
            d.ext     = 3'($urandom_range(0, 7));
            d.disp    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) - 32'd150 : $urandom;
            d.imm     = {$urandom, $urandom};
            d.rex_w   = 1'($urandom_range(0, 1));
            d.osz16   = 1'($urandom_range(0, 1));
            send(d);
        end
        w = 0;
        while ((exp_bytes.size() != 0 || !in_ready) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        bp_random = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bytes_left", 64'(exp_bytes.size()), 64'd0);
        chk("events_left", 64'(exp_evts.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
